// File: rtl/spram_ctrl_pkg.sv
// spram_ctrl_pkg: shared constants and request record for the single-port RAM controller.
package spram_ctrl_pkg;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int REQ_A = 16;
    localparam int REQ_D = 32;
    localparam int REQ_S = 2;
    typedef struct packed {
        logic             wnr;
        logic [REQ_A-1:0] addr;
        logic [REQ_D-1:0] wdata;
        logic [REQ_S-1:0] wstrb;
    } req_t;
endpackage

// File: rtl/spram_ctrl_fifo.sv
// spram_ctrl_fifo: two-entry response buffer with wrapping 1-bit pointers.
module spram_ctrl_fifo
    import spram_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
    assign full  = cnt == (PTR_W+1)'(FIFO_DEPTH);
    assign empty = cnt == '0;
    assign head  = mem[rptr];
endmodule

// File: rtl/spram_ctrl.sv
// spram_ctrl: request/response front end for a single-port RAM with 1-cycle registered reads.
// Reads are credit-limited so the in-flight read plus buffered data never exceed the FIFO depth.
module spram_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int A = 16,
    parameter int D = 32,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wnr,
    input  logic [A-1:0] req_addr,
    input  logic [D-1:0] req_wdata,
    input  logic [S-1:0] req_wstrb,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [D-1:0] resp_rdata,
    output logic         mem_en,
    output logic         mem_wnr,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_wdata,
    output logic [S-1:0] mem_wstrb,
    input  logic [D-1:0] mem_rdata
);
    logic         acc, pend_q, push, pop, full, empty;
    logic [D-1:0] head;
    // pend_q + count < 2 is equivalent to: not full, and not (one buffered while one in flight)
    assign req_ready  = !rst && (req_wnr || (!full && !(pend_q && !empty)));
    assign acc        = req_valid && req_ready;
    assign mem_en     = acc;
    assign mem_wnr    = req_wnr;
    assign mem_addr   = req_addr;
    assign mem_wdata  = req_wdata;
    assign mem_wstrb  = req_wstrb;
    assign resp_valid = !empty || pend_q;
    assign resp_rdata = (!empty || rst) ? head : mem_rdata;
    assign push       = pend_q && !(empty && resp_ready);
    assign pop        = resp_valid && resp_ready && !empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 1'b0;
        else pend_q <= acc && !req_wnr;
    end
    spram_ctrl_fifo #(.W(D)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (mem_rdata),
        .full (full),
        .empty(empty),
        .head (head)
    );
endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: directed table plus randomized traffic against a queue-based reference model.
module tb_spram_ctrl;
    import spram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_wnr = 1'b0, resp_ready = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, mem_en, mem_wnr;
    logic [31:0] resp_rdata, mem_wdata;
    logic [15:0] mem_addr;
    logic [1:0]  mem_wstrb;
    bit   [31:0] mem_rdata;

    spram_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wnr(req_wnr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_wnr(mem_wnr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: registered read, per-lane write, contents start at zero.
    bit [31:0] ram [65536];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wnr) begin
                if (mem_wstrb[0]) ram[mem_addr][15:0]  <= mem_wdata[15:0];
                if (mem_wstrb[1]) ram[mem_addr][31:16] <= mem_wdata[31:16];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Reference model: shadow memory and a queue of read data owed to the consumer.
    bit [31:0] shadow [65536];
    logic [31:0] owed [$];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        req_t        req;
        logic        rready;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_rdata;
    } vec_t;
    vec_t tbl [13];

    function automatic vec_t mk(logic v, logic w, logic [15:0] a, logic [31:0] d, logic [1:0] s,
                                logic rr, logic er, logic ev, logic [31:0] ed);
        vec_t t;
        t.valid = v; t.req.wnr = w; t.req.addr = a; t.req.wdata = d; t.req.wstrb = s;
        t.rready = rr; t.e_ready = er; t.e_valid = ev; t.e_rdata = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic rr, input logic has_exp,
                        input logic er, input logic ev, input logic [31:0] ed, input string tag);
        logic m_ready, m_valid, acc, hs;
        @(negedge clk);
        req_valid = v; req_wnr = w; req_addr = a; req_wdata = d; req_wstrb = s; resp_ready = rr;
        #1;
        m_ready = w || (owed.size() < 2);
        m_valid = owed.size() > 0;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(m_ready));
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'(m_valid));
        chk({tag, " mem_en"}, 32'(mem_en), 32'(v && m_ready));
        if (m_valid) chk({tag, " resp_rdata"}, resp_rdata, owed[0]);
        chk({tag, " credit<=2"}, 32'(int'(dut.pend_q) + int'(dut.u_fifo.cnt) <= 2), 32'd1);
        if (has_exp) begin
            chk({tag, " tbl ready"}, 32'(req_ready), 32'(er));
            chk({tag, " tbl valid"}, 32'(resp_valid), 32'(ev));
            if (ev) chk({tag, " tbl rdata"}, resp_rdata, ed);
        end
        acc = v && m_ready;
        hs  = m_valid && rr;
        @(posedge clk);
        if (hs) void'(owed.pop_front());
        if (acc && w) begin
            if (s[0]) shadow[a][15:0]  = d[15:0];
            if (s[1]) shadow[a][31:16] = d[31:16];
        end
        if (acc && !w) owed.push_back(shadow[a]);
    endtask

    task automatic rd(input logic [15:0] a, input logic rr, input string tag);
        step(1'b1, 1'b0, a, 32'h0, 2'b00, rr, 1'b0, 1'b0, 1'b0, 32'h0, tag);
    endtask

    task automatic idle(input logic rr, input string tag);
        step(1'b0, 1'b0, 16'h0, 32'h0, 2'b00, rr, 1'b0, 1'b0, 1'b0, 32'h0, tag);
    endtask

    task automatic reset_check(input string tag);
        #1;
        chk({tag, " rst req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, " rst resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " rst mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, " rst resp_rdata"}, resp_rdata, 32'h0);
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 16'h0004, 32'hDEADBEEF, 2'b01, 1, 1, 0, 32'h0);
        tbl[1]  = mk(1, 0, 16'h0004, 32'h0,        2'b00, 1, 1, 0, 32'h0);
        tbl[2]  = mk(1, 0, 16'h0010, 32'h0,        2'b00, 1, 1, 1, 32'h0000BEEF);
        tbl[3]  = mk(0, 0, 16'h0000, 32'h0,        2'b00, 1, 1, 1, 32'h0);
        tbl[4]  = mk(1, 1, 16'h0008, 32'h11112222, 2'b11, 0, 1, 0, 32'h0);
        tbl[5]  = mk(1, 1, 16'h0009, 32'h33334444, 2'b10, 0, 1, 0, 32'h0);
        tbl[6]  = mk(1, 0, 16'h0008, 32'h0,        2'b00, 0, 1, 0, 32'h0);
        tbl[7]  = mk(1, 0, 16'h0009, 32'h0,        2'b00, 0, 1, 1, 32'h11112222);
        tbl[8]  = mk(1, 0, 16'h0004, 32'h0,        2'b00, 0, 0, 1, 32'h11112222);
        tbl[9]  = mk(1, 0, 16'h0004, 32'h0,        2'b00, 1, 0, 1, 32'h11112222);
        tbl[10] = mk(1, 0, 16'h0004, 32'h0,        2'b00, 1, 1, 1, 32'h33330000);
        tbl[11] = mk(0, 0, 16'h0000, 32'h0,        2'b00, 1, 1, 1, 32'h0000BEEF);
        tbl[12] = mk(0, 0, 16'h0000, 32'h0,        2'b00, 1, 1, 0, 32'h0);

        reset_check("init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            step(tbl[i].valid, tbl[i].req.wnr, tbl[i].req.addr, tbl[i].req.wdata, tbl[i].req.wstrb,
                 tbl[i].rready, 1'b1, tbl[i].e_ready, tbl[i].e_valid, tbl[i].e_rdata,
                 $sformatf("tbl%0d", i));

        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 16'(i), $urandom, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "fill");
        // Streaming: the model demands resp_valid on every cycle after the first read.
        for (int i = 0; i < 8; i++) rd(16'(i), 1'b1, $sformatf("stream%0d", i));
        idle(1'b1, "stream_tail");
        chk("stream drained", 32'(owed.size()), 32'd0);

        rd(16'h0001, 1'b0, "pp_setup");
        idle(1'b0, "pp_hold");
        for (int i = 0; i < 8; i++) rd(16'(i + 2), 1'(i % 2 == 0), $sformatf("pushpop%0d", i));
        for (int i = 0; i < 4; i++) idle(1'b1, "pp_drain");
        chk("pushpop drained", 32'(owed.size()), 32'd0);

        rd(16'h0003, 1'b0, "rst_mid_read");
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        reset_check("mid");
        owed.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b1, "post_rst");

        for (int i = 0; i < 1500; i++)
            step(1'($urandom % 4 != 0), 1'($urandom % 3 == 0), 16'($urandom_range(0, 15)),
                 $urandom, 2'($urandom), 1'($urandom % 3 != 0), 1'b0, 1'b0, 1'b0, 32'h0, "rand");
        for (int i = 0; i < 4; i++) idle(1'b1, "final_drain");
        chk("final drained", 32'(owed.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
